// File: rtl/prog_loader.sv
// Instruction-memory loader: packs decoded fields into 8-bit words, writes them from address 0,
// then reads every word back against a shadow copy and reports done or error.
// Input handshake: a field set transfers on a rising edge where in_valid && in_ready are both high.
module prog_loader #(
   parameter int DEPTH  = 6,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] length,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_opcode,
   input  logic              in_rs,
   input  logic              in_rd,
   input  logic [2:0]        in_shamt,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [7:0]        mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [7:0]        mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W-1:0] err_addr,
   output logic [2:0]        dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD   = 3'd1,
      S_FLUSH  = 3'd2,
      S_VERIFY = 3'd3,
      S_DONE   = 3'd4,
      S_ERROR  = 3'd5
   } state_t;

   localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ONE_C   = ADDR_W'(1);

   state_t            state_q;
   logic [ADDR_W-1:0] cnt_q;
   logic [ADDR_W-1:0] len_q;
   logic              in_ready_q;
   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_waddr_q;
   logic [7:0]        mem_wdata_q;
   logic              done_q;
   logic              error_q;
   logic [ADDR_W-1:0] err_addr_q;
   logic [7:0]        shadow_q [DEPTH];

   logic [7:0]        word_in;
   logic [ADDR_W-1:0] cnt_inc;
   logic              beat;

   assign word_in = {in_opcode, in_rd, in_rs, in_shamt};
   assign cnt_inc = cnt_q + ONE_C;
   assign beat    = (state_q == S_LOAD) && in_valid && in_ready_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         in_ready_q  <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_waddr_q <= '0;
         mem_wdata_q <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_addr_q  <= '0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (start) begin
                  cnt_q  <= '0;
                  done_q <= 1'b0;
                  if (length == '0 || length > DEPTH_C) begin
                     state_q    <= S_ERROR;
                     error_q    <= 1'b1;
                     err_addr_q <= '0;
                  end else begin
                     state_q    <= S_LOAD;
                     len_q      <= length;
                     in_ready_q <= 1'b1;
                     error_q    <= 1'b0;
                  end
               end
            end
            S_LOAD: begin
               if (beat) begin
                  mem_wdata_q <= word_in;
                  mem_waddr_q <= cnt_q;
                  mem_we_q    <= 1'b1;
                  cnt_q       <= cnt_inc;
                  if (cnt_inc == len_q) begin
                     state_q    <= S_FLUSH;
                     in_ready_q <= 1'b0;
                  end
               end
            end
            // The final write is still in flight here; reading starts once it has landed.
            S_FLUSH: begin
               cnt_q   <= '0;
               state_q <= S_VERIFY;
            end
            S_VERIFY: begin
               if (mem_rdata != shadow_q[cnt_q]) begin
                  state_q    <= S_ERROR;
                  error_q    <= 1'b1;
                  err_addr_q <= cnt_q;
               end else if (cnt_q == len_q - ONE_C) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_inc;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (beat) shadow_q[cnt_q] <= word_in;
   end

   assign in_ready    = in_ready_q;
   assign mem_we      = mem_we_q;
   assign mem_waddr   = mem_waddr_q;
   assign mem_wdata   = mem_wdata_q;
   assign mem_raddr   = (state_q == S_VERIFY) ? cnt_q : '0;
   assign busy        = (state_q == S_LOAD) || (state_q == S_FLUSH) || (state_q == S_VERIFY);
   assign done        = done_q;
   assign error       = error_q;
   assign err_addr    = err_addr_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: behavioural memory with optional corrupted read-back, field driver,
// expected-write queue built from the packing rule, and per-scenario checks.
module tb_prog_loader;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = 3;
  localparam int W      = ADDR_W + 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] length = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [2:0]        in_opcode = '0;
  logic              in_rs = 1'b0;
  logic              in_rd = 1'b0;
  logic [2:0]        in_shamt = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr, mem_raddr, err_addr;
  logic [7:0]        mem_wdata, mem_rdata;
  logic              busy, done, error;
  logic [2:0]        dbg_state;

  logic [7:0]        mem_arr [8] = '{default: 8'h00};
  bit                corrupt_en = 1'b0;
  logic [ADDR_W-1:0] corrupt_addr = '0;
  logic [7:0]        corrupt_val = '0;

  logic [2:0] f_op [DEPTH];
  logic [2:0] f_sh [DEPTH];
  logic       f_rd [DEPTH];
  logic       f_rs [DEPTH];
  logic [7:0] exp_w [DEPTH];

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           obs_cyc[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_pass = 0;

  prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rs(in_rs), .in_rd(in_rd), .in_shamt(in_shamt),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .error(error), .err_addr(err_addr),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / memory model / write monitor ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      mem_arr[mem_waddr] = mem_wdata;
      obs_q.push_back({mem_waddr, mem_wdata});
      obs_cyc.push_back(cyc);
    end
  end

  assign mem_rdata = (corrupt_en && mem_raddr == corrupt_addr) ? corrupt_val : mem_arr[mem_raddr];

  // ---------------- model ----------------
  task automatic rand_fields();
    for (int i = 0; i < DEPTH; i++) begin
      f_op[i] = 3'($urandom_range(0, 7));
      f_rd[i] = 1'($urandom_range(0, 1));
      f_rs[i] = 1'($urandom_range(0, 1));
      f_sh[i] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic build_expected(input int len);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      int w;
      w = int'(f_op[i]) * 32 + int'(f_rd[i]) * 16 + int'(f_rs[i]) * 8 + int'(f_sh[i]);
      exp_w[i] = 8'(w);
      exp_q.push_back({ADDR_W'(i), 8'(w)});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic do_start(input int len, output int sc);
    @(negedge clk);
    obs_q.delete();
    obs_cyc.delete();
    start  = 1'b1;
    length = ADDR_W'(len);
    sc     = cyc;
  endtask

  // mode 0: back-to-back, 1: valid toggles 1,0,1,..., 2: random gaps.
  task automatic drive_load(input int len, input int mode, input int pulse_at, output bit to);
    int i;
    int budget;
    i = 0;
    budget = 0;
    to = 1'b0;
    while (i < len) begin
      @(negedge clk);
      budget++;
      if (budget > 200) begin
        to = 1'b1;
        in_valid = 1'b0;
        start = 1'b0;
        return;
      end
      if (mode == 0) in_valid = 1'b1;
      else if (mode == 1) in_valid = (budget % 2) == 1;
      else in_valid = ($urandom_range(0, 2) != 0);
      in_opcode = in_valid ? f_op[i] : 3'($urandom);
      in_rd     = in_valid ? f_rd[i] : 1'($urandom);
      in_rs     = in_valid ? f_rs[i] : 1'($urandom);
      in_shamt  = in_valid ? f_sh[i] : 3'($urandom);
      if (pulse_at == i) begin
        start  = 1'b1;
        length = ADDR_W'(1);
      end else begin
        start = 1'b0;
      end
      if (in_valid && in_ready) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic wait_end(output int ec, output bit to);
    to = 1'b1;
    ec = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (done || error) begin
        ec = cyc;
        to = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_checks++; if (in_ready !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_hs: got ready=%0b we=%0b want 0 0", in_ready, mem_we); else n_pass++;
    n_checks++; if (mem_waddr !== '0 || mem_wdata !== '0 || mem_raddr !== '0) $display("FAIL reset_mem: got wa=%0h wd=%0h ra=%0h want 0", mem_waddr, mem_wdata, mem_raddr); else n_pass++;
    n_checks++; if ({busy, done, error} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, error}); else n_pass++;
    n_checks++; if (err_addr !== '0) $display("FAIL reset_err_addr: got %0h want 0", err_addr); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_spec_vectors();
    logic [7:0] spec_w [DEPTH];
    int sc, ec;
    bit to, to2;
    spec_w = '{8'h00, 8'h10, 8'h96, 8'hD7, 8'hB2, 8'hF5};
    f_op = '{3'd0, 3'd0, 3'd4, 3'd6, 3'd5, 3'd7};
    f_rd = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    f_rs = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    f_sh = '{3'd0, 3'd0, 3'd6, 3'd7, 3'd2, 3'd5};
    do_start(6, sc);
    drive_load(6, 0, -1, to);
    wait_end(ec, to2);
    n_checks++; if (to || to2) $display("FAIL spec_timeout: got load=%0b end=%0b want 0 0", to, to2); else n_pass++;
    n_checks++; if (obs_q.size() != 6) $display("FAIL spec_count: got %0d want 6", obs_q.size()); else n_pass++;
    for (int i = 0; i < 6 && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== {ADDR_W'(i), spec_w[i]}) $display("FAIL spec_write%0d: got %0h want %0h", i, obs_q[i], {ADDR_W'(i), spec_w[i]}); else n_pass++;
    end
    n_checks++; if (obs_cyc.size() != 6 || obs_cyc[0] - sc != 2 || obs_cyc[5] - obs_cyc[0] != 5) $display("FAIL spec_we_timing: got first=%0d span=%0d want 2 5", obs_cyc.size() > 0 ? obs_cyc[0] - sc : -1, obs_cyc.size() == 6 ? obs_cyc[5] - obs_cyc[0] : -1); else n_pass++;
    n_checks++; if (ec - sc != 14) $display("FAIL spec_done_latency: got %0d want 14", ec - sc); else n_pass++;
    n_checks++; if ({done, error, busy} !== 3'b100) $display("FAIL spec_flags: got %b want 100", {done, error, busy}); else n_pass++;
  endtask

  task automatic test_gaps();
    int sc, ec;
    bit to, to2;
    rand_fields();
    build_expected(3);
    do_start(3, sc);
    drive_load(3, 1, -1, to);
    n_checks++; if (in_ready !== 1'b0) $display("FAIL gaps_ready_drop: got %0b want 0", in_ready); else n_pass++;
    wait_end(ec, to2);
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL gaps_count: got %0d want %0d", obs_q.size(), exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL gaps_write%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (to || to2 || done !== 1'b1) $display("FAIL gaps_done: got done=%0b timeout=%0b want 1 0", done, to | to2); else n_pass++;
  endtask

  task automatic test_corrupt();
    int sc, ec;
    bit to, to2;
    rand_fields();
    f_op[2] = 3'd1;
    build_expected(6);
    corrupt_en = 1'b1;
    corrupt_addr = ADDR_W'(2);
    corrupt_val = 8'hFF;
    do_start(6, sc);
    drive_load(6, 2, -1, to);
    wait_end(ec, to2);
    corrupt_en = 1'b0;
    n_checks++; if (obs_q.size() != 6) $display("FAIL corrupt_count: got %0d want 6", obs_q.size()); else n_pass++;
    n_checks++; if (to || to2 || {error, done, busy} !== 3'b100) $display("FAIL corrupt_flags: got %b want 100", {error, done, busy}); else n_pass++;
    n_checks++; if (err_addr !== ADDR_W'(2)) $display("FAIL corrupt_err_addr: got %0d want 2", err_addr); else n_pass++;
  endtask

  task automatic test_illegal();
    int lens [2];
    int sc;
    lens = '{0, 7};
    foreach (lens[j]) begin
      do_start(lens[j], sc);
      @(negedge clk);
      start = 1'b0;
      n_checks++; if ({error, done, busy, in_ready} !== 4'b1000) $display("FAIL illegal%0d_flags: got %b want 1000", lens[j], {error, done, busy, in_ready}); else n_pass++;
      n_checks++; if (err_addr !== '0) $display("FAIL illegal%0d_err_addr: got %0d want 0", lens[j], err_addr); else n_pass++;
      repeat (3) @(negedge clk);
      n_checks++; if (obs_q.size() != 0) $display("FAIL illegal%0d_no_write: got %0d want 0", lens[j], obs_q.size()); else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int sc, ec;
    bit to, to2;
    rand_fields();
    f_op[1] = 3'd5;
    do_start(5, sc);
    drive_load(2, 0, -1, to);
    n_checks++; if (mem_we !== 1'b1 || busy !== 1'b1) $display("FAIL rstmid_pre: got we=%0b busy=%0b want 1 1", mem_we, busy); else n_pass++;
    in_valid = 1'b1;
    in_opcode = f_op[2];
    #2 rst = 1'b1;
    #1;
    n_checks++; if ({in_ready, mem_we, busy, done, error} !== 5'b00000) $display("FAIL rstmid_flags: got %b want 00000", {in_ready, mem_we, busy, done, error}); else n_pass++;
    n_checks++; if (mem_waddr !== '0 || mem_wdata !== '0 || err_addr !== '0 || mem_raddr !== '0) $display("FAIL rstmid_regs: got wa=%0h wd=%0h ea=%0h ra=%0h want 0", mem_waddr, mem_wdata, err_addr, mem_raddr); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    rand_fields();
    build_expected(2);
    do_start(2, sc);
    drive_load(2, 0, -1, to);
    wait_end(ec, to2);
    n_checks++; if (obs_q.size() != 2) $display("FAIL rstmid_count: got %0d want 2", obs_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rstmid_write%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (to || to2 || done !== 1'b1 || ec - sc != 6) $display("FAIL rstmid_done: got done=%0b lat=%0d want 1 6", done, ec - sc); else n_pass++;
  endtask

  task automatic test_start_mid_load();
    int sc, ec;
    bit to, to2;
    rand_fields();
    build_expected(6);
    do_start(6, sc);
    drive_load(6, 2, 2, to);
    wait_end(ec, to2);
    n_checks++; if (obs_q.size() != 6) $display("FAIL midstart_count: got %0d want 6", obs_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL midstart_write%0d: got %0h want %0h", i, obs_q[i], exp_q[i]); else n_pass++;
    end
    n_checks++; if (to || to2 || {done, error} !== 2'b10) $display("FAIL midstart_done: got %b want 10", {done, error}); else n_pass++;
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int sc, ec, len, mode, a;
      bit to, to2, bad;
      len = $urandom_range(1, DEPTH);
      mode = $urandom_range(0, 2);
      bad = 1'($urandom_range(0, 1));
      a = $urandom_range(0, len - 1);
      rand_fields();
      build_expected(len);
      corrupt_en = bad;
      corrupt_addr = ADDR_W'(a);
      corrupt_val = exp_w[a] ^ 8'($urandom_range(1, 255));
      do_start(len, sc);
      drive_load(len, mode, -1, to);
      wait_end(ec, to2);
      corrupt_en = 1'b0;
      n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand%0d_count: got %0d want %0d", r, obs_q.size(), exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
        n_checks++; if (obs_q[i] !== exp_q[i]) $display("FAIL rand%0d_write%0d: got %0h want %0h", r, i, obs_q[i], exp_q[i]); else n_pass++;
      end
      if (bad) begin
        n_checks++; if (to || to2 || {error, done} !== 2'b10 || err_addr !== ADDR_W'(a)) $display("FAIL rand%0d_error: got err=%0b done=%0b ea=%0d want 1 0 %0d", r, error, done, err_addr, a); else n_pass++;
      end else begin
        n_checks++; if (to || to2 || {error, done} !== 2'b01) $display("FAIL rand%0d_done: got err=%0b done=%0b want 0 1", r, error, done); else n_pass++;
        if (mode == 0) begin
          n_checks++; if (ec - sc != 2 * len + 2) $display("FAIL rand%0d_latency: got %0d want %0d", r, ec - sc, 2 * len + 2); else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_gaps();
    test_corrupt();
    test_illegal();
    test_reset_mid();
    test_start_mid_load();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
